// File: rtl/cu_fetch.sv
// cu_fetch: instruction fetch stage of the CU.
// Issues one-cycle read strobes to instruction memory, captures the returned
// word into Cu_IR, presents it to decode with a valid/ready handshake and owns
// the PC (+4 or +pc_increment on a taken redirect).
// Ports:
//   soc_clk, IF_reset          clock, asynchronous active-high reset
//   fetch_en                   enable fetching (sampled in IDLE and at handshake)
//   mem_req, mem_addr          read strobe / address to instruction memory
//   mem_rvalid, mem_rdata,     read response, bus error qualified by mem_rvalid
//   mem_err
//   Cu_IR, IR_valid, ID_ready  instruction to decode with valid/ready handshake
//   redirect, pc_increment     taken branch and its signed offset, at handshake
//   pc_out                     address of the instruction held / being fetched
//   fetch_fault                sticky fault (bus error, timeout, misaligned PC)
module cu_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        soc_clk,
  input  logic        IF_reset,
  input  logic        fetch_en,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic [31:0] Cu_IR,
  output logic        IR_valid,
  input  logic        ID_ready,
  input  logic        redirect,
  input  logic [31:0] pc_increment,
  output logic [31:0] pc_out,
  output logic        fetch_fault
);

  localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]       NOP      = 32'h0000_0013;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [31:0]      pc_d, ir_d, addr_d, next_pc;
  logic             ir_valid_d, req_d, fault_d;

  // Next state and next values of every registered output
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    pc_d       = pc_out;
    ir_d       = Cu_IR;
    ir_valid_d = IR_valid;
    req_d      = 1'b0;
    addr_d     = mem_addr;
    fault_d    = fetch_fault;
    next_pc    = redirect ? (pc_out + pc_increment) : (pc_out + 32'd4);

    case (state)
      S_IDLE: begin
        if (fetch_en) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          addr_d  = pc_out;
        end
      end

      S_REQ: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end

      S_WAIT: begin
        cnt_d = cnt + CNT_W'(1);
        // A response on the last allowed cycle still beats the timeout
        if (mem_rvalid && !mem_err) begin
          ir_d       = mem_rdata;
          ir_valid_d = 1'b1;
          state_d    = S_HOLD;
        end else if (mem_rvalid || (cnt == CNT_LAST)) begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end
      end

      S_HOLD: begin
        if (ID_ready) begin
          ir_valid_d = 1'b0;
          // A misaligned target faults; pc_out keeps the branch address
          if (next_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            pc_d = next_pc;
            if (fetch_en) begin
              state_d = S_REQ;
              req_d   = 1'b1;
              addr_d  = next_pc;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end

      S_FAULT: begin
        fault_d    = 1'b1;
        ir_valid_d = 1'b0;
      end

      default: begin
        state_d    = S_IDLE;
        ir_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge soc_clk or posedge IF_reset) begin
    if (IF_reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pc_out      <= RESET_PC;
      Cu_IR       <= NOP;
      IR_valid    <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      pc_out      <= pc_d;
      Cu_IR       <= ir_d;
      IR_valid    <= ir_valid_d;
      mem_req     <= req_d;
      mem_addr    <= addr_d;
      fetch_fault <= fault_d;
    end
  end

endmodule

// File: tb/tb_cu_fetch.sv
// tb_cu_fetch: self-checking bench for cu_fetch.
// A memory responder answers each request; the expected {pc, word} pair is
// queued when the response is driven and compared at the decode handshake.
module tb_cu_fetch;

  logic        soc_clk = 1'b0;
  logic        IF_reset;
  logic        fetch_en;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [31:0] Cu_IR;
  logic        IR_valid;
  logic        ID_ready;
  logic        redirect;
  logic [31:0] pc_increment;
  logic [31:0] pc_out;
  logic        fetch_fault;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } sb_t;

  sb_t         sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_pc;

  always #5 soc_clk = ~soc_clk;

  cu_fetch dut (
    .soc_clk      (soc_clk),
    .IF_reset     (IF_reset),
    .fetch_en     (fetch_en),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .mem_err      (mem_err),
    .Cu_IR        (Cu_IR),
    .IR_valid     (IR_valid),
    .ID_ready     (ID_ready),
    .redirect     (redirect),
    .pc_increment (pc_increment),
    .pc_out       (pc_out),
    .fetch_fault  (fetch_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge
  task automatic tick();
    @(negedge soc_clk);
  endtask

  task automatic wait_req();
    int i;
    i = 0;
    while (!mem_req && i < 8) begin
      tick();
      i++;
    end
    check("req_seen", 32'(mem_req), 32'd1);
  endtask

  task automatic do_reset();
    fetch_en   = 1'b0;
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    redirect   = 1'b0;
    IF_reset   = 1'b1;
    tick();
    IF_reset   = 1'b0;
    exp_pc     = 32'h0;
    sb.delete();
  endtask

  // One fetch: d extra WAIT cycles before the response, hold cycles with
  // ID_ready low, then a handshake with the given redirect / offset.
  task automatic do_fetch(input int d, input logic [31:0] data, input int hold,
                          input logic rd, input logic [31:0] inc, input logic drop);
    sb_t         e;
    logic [31:0] npc;
    wait_req();
    check("mem_addr", mem_addr, exp_pc);
    check("pc_req", pc_out, exp_pc);
    if (drop) fetch_en = 1'b0;
    tick();
    check("req_pulse", 32'(mem_req), 32'd0);
    repeat (d) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    sb.push_back('{pc: exp_pc, ir: data});
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    check("ir_valid", 32'(IR_valid), 32'd1);
    ID_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_ir", Cu_IR, sb[0].ir);
      check("hold_pc", pc_out, exp_pc);
      check("hold_vld", 32'(IR_valid), 32'd1);
      check("hold_req", 32'(mem_req), 32'd0);
    end
    ID_ready     = 1'b1;
    redirect     = rd;
    pc_increment = inc;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("ir", Cu_IR, e.ir);
      check("pc", pc_out, e.pc);
    end
    npc = rd ? (exp_pc + inc) : (exp_pc + 32'd4);
    tick();
    redirect     = 1'b0;
    pc_increment = 32'h0;
    check("vld_drop", 32'(IR_valid), 32'd0);
    if (npc[1:0] == 2'b00) exp_pc = npc;
  endtask

  initial begin
    IF_reset     = 1'b1;
    fetch_en     = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = 32'h0;
    mem_err      = 1'b0;
    ID_ready     = 1'b0;
    redirect     = 1'b0;
    pc_increment = 32'h0;
    exp_pc       = 32'h0;
    tick();
    tick();
    check("rst_pc", pc_out, 32'h0);
    check("rst_ir", Cu_IR, 32'h0000_0013);
    check("rst_vld", 32'(IR_valid), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    IF_reset = 1'b0;
    tick();
    check("idle_req", 32'(mem_req), 32'd0);

    // First fetch latency: request the cycle after fetch_en
    fetch_en = 1'b1;
    ID_ready = 1'b1;
    tick();
    check("lat_req", 32'(mem_req), 32'd1);
    do_fetch(0, 32'h0010_0093, 0, 1'b0, 32'h0, 1'b0);
    do_fetch(2, $urandom() | 32'h3, 5, 1'b0, 32'h0, 1'b0);
    do_fetch(0, $urandom() | 32'h3, 0, 1'b1, 32'h0000_00F8, 1'b0);
    do_fetch(1, $urandom() | 32'h3, 0, 1'b1, 32'hFFFF_FFF0, 1'b0);
    // Response lands on the timeout cycle and must win
    do_fetch(15, $urandom() | 32'h3, 0, 1'b1, 32'h0000_0010, 1'b0);
    check("no_fault", 32'(fetch_fault), 32'd0);
    // Wrap-around of the PC
    do_fetch(0, $urandom() | 32'h3, 0, 1'b1, 32'hFFFF_FEFC, 1'b0);
    do_fetch(0, $urandom() | 32'h3, 0, 1'b0, 32'h0, 1'b0);
    check("wrap_pc", exp_pc, 32'h0);
    // fetch_en dropped mid-fetch: delivered, then IDLE
    do_fetch(0, $urandom() | 32'h3, 0, 1'b1, 32'h0000_0100, 1'b1);
    repeat (3) begin
      tick();
      check("drop_req", 32'(mem_req), 32'd0);
      check("drop_pc", pc_out, 32'h0000_0100);
    end
    fetch_en = 1'b1;
    // Misaligned redirect target faults, PC keeps the branch address
    do_fetch(0, $urandom() | 32'h3, 2, 1'b1, 32'h0000_0006, 1'b0);
    check("mis_fault", 32'(fetch_fault), 32'd1);
    check("mis_pc", pc_out, 32'h0000_0100);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    repeat (4) begin
      tick();
      check("flt_req", 32'(mem_req), 32'd0);
      check("flt_vld", 32'(IR_valid), 32'd0);
      check("flt_sticky", 32'(fetch_fault), 32'd1);
      check("flt_pc", pc_out, 32'h0000_0100);
    end
    mem_rvalid = 1'b0;

    // Timeout: 16 WAIT cycles without a response
    do_reset();
    check("rst2_fault", 32'(fetch_fault), 32'd0);
    fetch_en = 1'b1;
    wait_req();
    check("to_addr", mem_addr, 32'h0);
    repeat (16) tick();
    check("to_early", 32'(fetch_fault), 32'd0);
    tick();
    check("to_fault", 32'(fetch_fault), 32'd1);
    check("to_vld", 32'(IR_valid), 32'd0);

    // Bus error response
    do_reset();
    fetch_en = 1'b1;
    wait_req();
    tick();
    mem_rvalid = 1'b1;
    mem_err    = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    check("err_fault", 32'(fetch_fault), 32'd1);
    check("err_vld", 32'(IR_valid), 32'd0);

    // Reset during WAIT, then a late response is ignored
    do_reset();
    fetch_en = 1'b1;
    wait_req();
    tick();
    fetch_en = 1'b0;
    IF_reset = 1'b1;
    tick();
    check("mid_rst_pc", pc_out, 32'h0);
    IF_reset   = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5677;
    tick();
    mem_rvalid = 1'b0;
    repeat (2) begin
      tick();
      check("late_vld", 32'(IR_valid), 32'd0);
      check("late_pc", pc_out, 32'h0);
      check("late_ir", Cu_IR, 32'h0000_0013);
      check("late_req", 32'(mem_req), 32'd0);
      check("late_fault", 32'(fetch_fault), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
